// File: rtl/blur_seq_pkg.sv
// Shared types and constants for the blur frame sequencer.
//   seq_state_t  : frame sequencer FSM states
//   KERNEL_*     : filter kernel select encodings
//   clamp_kernel : maps an out-of-range kernel request onto the largest kernel
package blur_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

  localparam logic [2:0] KERNEL_1X1 = 3'b000;
  localparam logic [2:0] KERNEL_3X3 = 3'b001;
  localparam logic [2:0] KERNEL_5X5 = 3'b010;

  function automatic logic [2:0] clamp_kernel(input logic [2:0] req);
    logic [2:0] sel;
    case (req)
      KERNEL_1X1, KERNEL_3X3, KERNEL_5X5: sel = req;
      default:                            sel = KERNEL_5X5;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/blur_raster_counter.sv
// Raster-order position counter: tracks row, column and linear address.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : return to row 0 / col 0 / addr 0 (wins over enable)
//   enable     : advance one pixel; column wraps at last_col into the next row
//   last_row   : frame height - 1
//   last_col   : frame width - 1
//   addr       : current linear address
//   last       : current position is the final pixel of the frame
module blur_raster_counter #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DIM_W-1:0]  last_row,
  input  logic [DIM_W-1:0]  last_col,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [DIM_W-1:0]  row_q, row_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (enable) begin
      addr_d = addr_q + ADDR_W'(1);
      if (col_q == last_col) begin
        col_d = '0;
        row_d = row_q + DIM_W'(1);
      end else begin
        col_d = col_q + DIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;
  assign last = (row_q == last_row) && (col_q == last_col);

endmodule

// File: rtl/blur_frame_sequencer.sv
// Sequences one frame through the blurring filter: reads the input frame
// buffer in raster order, streams pixels into the filter with a frame-stable
// kernel select, and writes filter results in raster order to the output
// frame buffer.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start/busy/done       : frame handshake (start ignored unless idle)
//   freq_flag_req         : requested kernel, clamped to 5x5 when invalid
//   image_height/width    : frame size, sampled on an accepted start
//   err_timeout           : drain watchdog tripped, sticky until next start
//   rd_en/rd_addr/rd_data : input buffer port, data returns 1 cycle after rd_en
//   filt_*                : filter data/valid/kernel in, result/valid out
//   wr_en/wr_addr/wr_data : output buffer write port
// Configuration:
//   SEQ_TIMEOUT_EN : when defined, a drain watchdog ends the frame after
//                    TIMEOUT_CYCLES cycles without a filter output.
module blur_frame_sequencer
  import blur_seq_pkg::*;
#(
  parameter int DATA_W         = 12,
  parameter int DIM_W          = 10,
  parameter int ADDR_W         = 17,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        freq_flag_req,
  input  logic [DIM_W-1:0]  image_height,
  input  logic [DIM_W-1:0]  image_width,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              filt_ready_in,
  output logic [2:0]        filt_freq_flag,
  output logic [DATA_W-1:0] filt_data_in,
  input  logic              filt_ready_out,
  input  logic [DATA_W-1:0] filt_data_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_t        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_timeout_q, err_timeout_d;
  logic              rd_en_q, rd_en_d;
  logic              filt_ready_in_q, filt_ready_in_d;
  logic [2:0]        flag_q, flag_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  width_q, width_d;
  // Set once N results have been written; later results are dropped.
  logic              out_full_q, out_full_d;

  logic              frame_clear;
  logic              in_enable, in_last;
  logic [ADDR_W-1:0] in_addr;
  logic              out_enable, out_last;
  logic [ADDR_W-1:0] out_addr;
  logic              frame_empty;

  // H*W is zero exactly when either dimension is zero.
  assign frame_empty = (image_height == '0) || (image_width == '0);

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  blur_raster_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_in_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (frame_clear),
    .enable   (in_enable),
    .last_row (height_q - DIM_W'(1)),
    .last_col (width_q - DIM_W'(1)),
    .addr     (in_addr),
    .last     (in_last)
  );

  blur_raster_counter #(.DIM_W(DIM_W), .ADDR_W(ADDR_W)) u_out_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (frame_clear),
    .enable   (out_enable),
    .last_row (height_q - DIM_W'(1)),
    .last_col (width_q - DIM_W'(1)),
    .addr     (out_addr),
    .last     (out_last)
  );

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_timeout_d   = err_timeout_q;
    rd_en_d         = 1'b0;
    // Read data returns one cycle after the strobe, so the filter valid
    // is simply the read strobe delayed by one cycle.
    filt_ready_in_d = rd_en_q;
    flag_d          = flag_q;
    wr_en_d         = 1'b0;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    height_d        = height_q;
    width_d         = width_q;
    out_full_d      = out_full_q;
    frame_clear     = 1'b0;
    in_enable       = 1'b0;
    out_enable      = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    wd_d = '0;
    if ((state_q == DRAIN) && !filt_ready_out) begin
      wd_d = wd_q + WD_W'(1);
    end
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          height_d      = image_height;
          width_d       = image_width;
          flag_d        = clamp_kernel(freq_flag_req);
          err_timeout_d = 1'b0;
          busy_d        = 1'b1;
          frame_clear   = 1'b1;
          // An empty frame has nothing to write, so the output side starts full.
          out_full_d    = frame_empty;
          if (frame_empty) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end
      end
      FETCH, STREAM: begin
        // The read for the current address is being issued this cycle.
        if (in_last) begin
          state_d = DRAIN;
        end else begin
          in_enable = 1'b1;
          rd_en_d   = 1'b1;
          state_d   = STREAM;
        end
      end
      DRAIN: begin
        if (out_full_q) begin
          state_d = DONE;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
          err_timeout_d = 1'b1;
          state_d       = DONE;
        end
`endif
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Result capture runs alongside the FSM for the whole busy period.
    if (busy_q && filt_ready_out && !out_full_q) begin
      wr_en_d    = 1'b1;
      wr_addr_d  = out_addr;
      wr_data_d  = filt_data_out;
      out_enable = 1'b1;
      if (out_last) begin
        out_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_timeout_q   <= 1'b0;
      rd_en_q         <= 1'b0;
      filt_ready_in_q <= 1'b0;
      flag_q          <= 3'b000;
      wr_en_q         <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      height_q        <= '0;
      width_q         <= '0;
      out_full_q      <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_q            <= '0;
`endif
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_timeout_q   <= err_timeout_d;
      rd_en_q         <= rd_en_d;
      filt_ready_in_q <= filt_ready_in_d;
      flag_q          <= flag_d;
      wr_en_q         <= wr_en_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      height_q        <= height_d;
      width_q         <= width_d;
      out_full_q      <= out_full_d;
`ifdef SEQ_TIMEOUT_EN
      wd_q            <= wd_d;
`endif
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err_timeout    = err_timeout_q;
  assign rd_en          = rd_en_q;
  assign rd_addr        = in_addr;
  assign filt_ready_in  = filt_ready_in_q;
  assign filt_freq_flag = flag_q;
  // Gated so the filter sees zero data whenever no pixel is presented.
  assign filt_data_in   = filt_ready_in_q ? rd_data : '0;
  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_data        = wr_data_q;

endmodule

// File: tb/tb_blur_frame_sequencer.sv
module tb_blur_frame_sequencer;
  localparam int DATA_W = 12;
  localparam int DIM_W  = 10;
  localparam int ADDR_W = 17;
  localparam int TMO    = 64;
  localparam int LAT    = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        freq_flag_req;
  logic [DIM_W-1:0]  image_height, image_width;
  logic              busy, done, err_timeout, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              filt_ready_in;
  logic [2:0]        filt_freq_flag;
  logic [DATA_W-1:0] filt_data_in;
  logic              filt_ready_out;
  logic [DATA_W-1:0] filt_data_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  always #5 clk = ~clk;

  blur_frame_sequencer #(
    .DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .freq_flag_req(freq_flag_req),
    .image_height(image_height), .image_width(image_width),
    .busy(busy), .done(done), .err_timeout(err_timeout),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .filt_ready_in(filt_ready_in), .filt_freq_flag(filt_freq_flag),
    .filt_data_in(filt_data_in), .filt_ready_out(filt_ready_out),
    .filt_data_out(filt_data_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Stand-in filter transform; the bench predicts writes as xform(pixel[i]).
  function automatic logic [DATA_W-1:0] xform(input logic [DATA_W-1:0] d);
    return {d[4:0], d[11:5]} ^ 12'h6B5;
  endfunction

  // Input frame buffer: one-cycle read latency.
  logic [DATA_W-1:0] in_mem [0:1023];
  always @(posedge clk) if (rd_en) rd_data <= in_mem[rd_addr[9:0]];

  // Filter model: fixed latency LAT; optionally drops the last 5 results.
  logic [LAT-1:0]    vpipe;
  logic [DATA_W-1:0] dpipe [LAT];
  int in_idx;
  int frame_n;
  bit drop_mode;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe  <= '0;
      in_idx <= 0;
    end else begin
      vpipe    <= {vpipe[LAT-2:0], filt_ready_in && !(drop_mode && in_idx >= frame_n - 5)};
      dpipe[0] <= xform(filt_data_in);
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
      if (start && !busy) in_idx <= 0;
      else if (filt_ready_in) in_idx <= in_idx + 1;
    end
  end
  assign filt_ready_out = vpipe[LAT-1];
  assign filt_data_out  = dpipe[LAT-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int h;
    int w;
    int flag_req;
    int exp_flag;
    int exp_n;
    int second_at;
    int change_at;
  } vec_t;

  function automatic int ref_flag(input int f);
    return (f > 2) ? 2 : f;
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) in_mem[i] = 12'($urandom);
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int n_rd = 0, n_rdy = 0, rdy_first = -1, rdy_last = -1;
    int n_done = 0, done_cyc = -1, busy_cnt = 0, flag_bad = 0;
    int busy_after = 0, wr_bad = 0, n_wr = 0, cyc = 0, post = 0;
    bit seen_done = 0;
    fill_mem();
    frame_n   = v.exp_n;
    drop_mode = 0;
    @(negedge clk);
    start         = 1'b1;
    image_height  = DIM_W'(v.h);
    image_width   = DIM_W'(v.w);
    freq_flag_req = 3'(v.flag_req);
    while (post < 3 && cyc < v.exp_n + 100) begin
      @(negedge clk);
      cyc++;
      if (rd_en) n_rd++;
      if (filt_ready_in) begin
        if (n_rdy == 0) rdy_first = cyc;
        rdy_last = cyc;
        n_rdy++;
      end
      if (wr_en) begin
        if (n_wr >= 1024 || wr_addr !== ADDR_W'(n_wr) || wr_data !== xform(in_mem[n_wr])) wr_bad++;
        n_wr++;
      end
      if (busy) begin
        busy_cnt++;
        if (filt_freq_flag !== 3'(v.exp_flag)) flag_bad++;
      end
      if (seen_done) begin
        post++;
        if (busy) busy_after++;
      end
      if (done) begin
        n_done++;
        if (!seen_done) done_cyc = cyc;
        seen_done = 1;
      end
      start = (cyc == v.second_at);
      if (cyc == v.change_at) freq_flag_req = 3'b000;
    end
    start = 1'b0;
    chk({tag, ".done_seen"}, seen_done, 1);
    chk({tag, ".n_done"}, n_done, 1);
    chk({tag, ".n_rd"}, n_rd, v.exp_n);
    chk({tag, ".n_feed"}, n_rdy, v.exp_n);
    chk({tag, ".n_wr"}, n_wr, v.exp_n);
    chk({tag, ".wr_seq_bad"}, wr_bad, 0);
    chk({tag, ".flag_bad"}, flag_bad, 0);
    chk({tag, ".busy_after_done"}, busy_after, 0);
    chk({tag, ".flag_held"}, filt_freq_flag, v.exp_flag);
    if (v.exp_n > 0) begin
      chk({tag, ".feed_first"}, rdy_first, 2);
      chk({tag, ".feed_span"}, rdy_last - rdy_first + 1, v.exp_n);
    end else begin
      chk({tag, ".done_cyc"}, done_cyc, 2);
      chk({tag, ".busy_cycles"}, busy_cnt, 1);
    end
    $display("frame %s: %0dx%0d flag_req=%0d writes=%0d done_at=%0d", tag, v.h, v.w, v.flag_req, n_wr, done_cyc);
  endtask

  task automatic run_drop_frame();
    int cyc = 0, n_wr = 0, last_fro = -1, done_cyc = -1, n_done = 0;
    bit err_seen = 0, err_at_done = 0;
    vec_t nv;
    fill_mem();
    frame_n   = 36;
    drop_mode = 1;
    @(negedge clk);
    start = 1'b1; image_height = 10'd6; image_width = 10'd6; freq_flag_req = 3'b001;
    while (cyc < 400 && done_cyc < 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (filt_ready_out) last_fro = cyc;
      if (wr_en) n_wr++;
      if (err_timeout) err_seen = 1;
      if (done) begin n_done++; done_cyc = cyc; err_at_done = err_timeout; end
`ifndef SEQ_TIMEOUT_EN
      if (cyc >= 300) break;
`endif
    end
    drop_mode = 0;
    chk("drop.n_wr", n_wr, 31);
`ifdef SEQ_TIMEOUT_EN
    chk("drop.n_done", n_done, 1);
    chk("drop.err_at_done", err_at_done, 1);
    chk("drop.gap_in_range", (done_cyc - last_fro >= TMO && done_cyc - last_fro <= TMO + 8), 1);
    repeat (5) @(negedge clk);
    chk("drop.err_sticky", err_timeout, 1);
    nv = '{4, 5, 1, 1, 20, -1, -1};
    run_frame(nv, "after_timeout");
    chk("drop.err_cleared", err_timeout, 0);
`else
    chk("drop.n_done", n_done, 0);
    chk("drop.err_seen", err_seen, 0);
    chk("drop.busy_stuck", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("drop.busy_after_reset", busy, 0);
`endif
    $display("drop frame: writes=%0d done_at=%0d last_out=%0d err=%0d", n_wr, done_cyc, last_fro, err_seen);
  endtask

  vec_t vecs[12];
  int   cnt, cyc, n_done;
  vec_t pv;

  initial begin
    // Directed rows, then randomized rows whose expectations come from the rules.
    vecs[0] = '{15, 15, 1, 1, 225, -1, -1};
    vecs[1] = '{15, 15, 7, 2, 225, -1, 30};
    vecs[2] = '{0, 15, 1, 1, 0, -1, -1};
    vecs[3] = '{15, 15, 2, 2, 225, 50, -1};
    vecs[4] = '{1, 1, 0, 0, 1, -1, -1};
    vecs[5] = '{3, 4, 4, 2, 12, -1, -1};
    vecs[6] = '{7, 1, 3, 2, 7, -1, -1};
    vecs[7] = '{5, 0, 0, 0, 0, -1, -1};
    for (int k = 8; k < 12; k++) begin
      vecs[k].h         = int'($urandom_range(0, 10));
      vecs[k].w         = int'($urandom_range(1, 12));
      vecs[k].flag_req  = int'($urandom_range(0, 7));
      vecs[k].exp_flag  = ref_flag(vecs[k].flag_req);
      vecs[k].exp_n     = vecs[k].h * vecs[k].w;
      vecs[k].second_at = -1;
      vecs[k].change_at = int'($urandom_range(3, 20));
    end

    reset = 1'b1; start = 1'b0; freq_flag_req = 3'b000;
    image_height = '0; image_width = '0; drop_mode = 0; frame_n = 0;
    repeat (3) @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.outs_or", |{done, err_timeout, rd_en, rd_addr, filt_ready_in, filt_freq_flag,
                           filt_data_in, wr_en, wr_addr, wr_data}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);
    chk("idle.rd_en", rd_en, 0);

    for (int i = 0; i < 12; i++) run_frame(vecs[i], $sformatf("v%0d", i));

    // Reset while pixel 100 is being presented.
    fill_mem();
    frame_n = 225;
    @(negedge clk);
    start = 1'b1; image_height = 10'd15; image_width = 10'd15; freq_flag_req = 3'b001;
    cnt = 0;
    cyc = 0;
    while (cnt < 101 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (filt_ready_in) cnt++;
    end
    chk("midrst.reached", cnt, 101);
    reset = 1'b1;
    #1;
    chk("midrst.busy", busy, 0);
    chk("midrst.outs_or", |{done, err_timeout, rd_en, rd_addr, filt_ready_in, filt_freq_flag,
                            filt_data_in, wr_en, wr_addr, wr_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst.no_done", n_done, 0);
    pv = '{3, 3, 1, 1, 9, -1, -1};
    run_frame(pv, "post_reset");

    run_drop_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
